alu_32bit: RTL and testbench

//   Registered 32-bit integer ALU for the MIPS datapath (execute stage).

---
 rtl/alu_32bit.sv | 65 ++++++
 tb/tb_alu_32bit.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_32bit.sv
// Registered integer ALU for the execute stage: AND/OR/ADD/SUB/MUL/SLT under a 3-bit code.
// Result, zero flag and valid are captured together on the rising clock edge.
module alu_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic [2:0]       ALU_Control,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero_Flag
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpSlt = 3'b110;

  logic [WIDTH-1:0] w_result;
  logic             w_lt;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_valid;

  assign w_lt = $signed(Src1) < $signed(Src2);

  // Unused codes (011, 111) fall through to zero.
  always_comb begin
    w_result = '0;
    case (ALU_Control)
      OpAnd:   w_result = Src1 & Src2;
      OpOr:    w_result = Src1 | Src2;
      OpAdd:   w_result = Src1 + Src2;
      OpSub:   w_result = Src1 - Src2;
      OpMul:   w_result = Src1 * Src2;
      OpSlt:   w_result = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
        r_zero   <= (w_result == '0);
      end
    end
  end

  assign ALU_Result = r_result;
  assign Zero_Flag  = r_zero;
  assign out_valid  = r_valid;

endmodule

// File: tb/tb_alu_32bit.sv
// Directed bench for alu_32bit: hand-computed vectors checked one cycle after capture.
module tb_alu_32bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] Src1;
  logic [31:0] Src2;
  logic [2:0]  ALU_Control;
  logic        out_valid;
  logic [31:0] ALU_Result;
  logic        Zero_Flag;

  int errors = 0;
  int checks = 0;

  alu_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .Src1        (Src1),
    .Src2        (Src2),
    .ALU_Control (ALU_Control),
    .out_valid   (out_valid),
    .ALU_Result  (ALU_Result),
    .Zero_Flag   (Zero_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation, then sample 1 time unit after the capturing edge.
  task automatic op(input logic v, input logic [2:0] ctl, input logic [31:0] a,
                    input logic [31:0] b);
    in_valid    = v;
    ALU_Control = ctl;
    Src1        = a;
    Src2        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] res, input logic z,
                            input logic v);
    chk({tag, "_result"}, ALU_Result, res);
    chk({tag, "_zero"}, {31'd0, Zero_Flag}, {31'd0, z});
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    ALU_Control = 3'b010;
    Src1 = 32'd7;
    Src2 = 32'd8;
    // Edges during reset must not capture.
    repeat (2) @(posedge clk);
    #1;
    expect_res("reset", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    op(1'b1, 3'b000, 32'd10, 32'd1);               expect_res("and", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b001, 32'd10, 32'd0);               expect_res("or", 32'd10, 1'b0, 1'b1);
    op(1'b1, 3'b010, 32'd10, 32'd15);              expect_res("add", 32'd25, 1'b0, 1'b1);
    op(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);        expect_res("add_wrap", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1);        expect_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    op(1'b1, 3'b100, 32'd10, 32'd5);               expect_res("sub", 32'd5, 1'b0, 1'b1);
    op(1'b1, 3'b100, 32'd5, 32'd10);               expect_res("sub_neg", 32'hFFFF_FFFB, 1'b0, 1'b1);
    op(1'b1, 3'b100, 32'd0, 32'd1);                expect_res("sub_0m1", 32'hFFFF_FFFF, 1'b0, 1'b1);
    op(1'b1, 3'b101, 32'd10, 32'd2);               expect_res("mul", 32'd20, 1'b0, 1'b1);
    op(1'b1, 3'b101, 32'h0001_0000, 32'h0001_0000); expect_res("mul_ovf", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd3);        expect_res("mul_neg", 32'hFFFF_FFFD, 1'b0, 1'b1);
    op(1'b1, 3'b110, 32'd1, 32'd2);                expect_res("slt_lt", 32'd1, 1'b0, 1'b1);
    op(1'b1, 3'b110, 32'd2, 32'd1);                expect_res("slt_gt", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1);        expect_res("slt_neg", 32'd1, 1'b0, 1'b1);
    op(1'b1, 3'b110, 32'h8000_0000, 32'h7FFF_FFFF); expect_res("slt_min", 32'd1, 1'b0, 1'b1);
    op(1'b1, 3'b110, 32'h1234_5678, 32'h1234_5678); expect_res("slt_eq", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b010, 32'd10, 32'd15);              expect_res("add2", 32'd25, 1'b0, 1'b1);
    op(1'b1, 3'b111, 32'd1, 32'd2);                expect_res("nop111", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b001, 32'hA5A5_0000, 32'h0000_5A5A); expect_res("or2", 32'hA5A5_5A5A, 1'b0, 1'b1);
    op(1'b1, 3'b011, 32'd1, 32'd2);                expect_res("nop011", 32'd0, 1'b1, 1'b1);
    op(1'b1, 3'b000, 32'hF0F0_FFFF, 32'h0FF0_1234); expect_res("and2", 32'h00F0_1234, 1'b0, 1'b1);

    // in_valid low: valid drops, result and flag hold even with new operands.
    op(1'b0, 3'b010, 32'd1, 32'd1);                expect_res("hold1", 32'h00F0_1234, 1'b0, 1'b0);
    op(1'b0, 3'b000, 32'd0, 32'd0);                expect_res("hold2", 32'h00F0_1234, 1'b0, 1'b0);

    // Asynchronous reset between edges with a nonzero result held.
    op(1'b1, 3'b010, 32'd40, 32'd2);               expect_res("pre_rst", 32'd42, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    expect_res("async_rst", 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b1, 3'b100, 32'd100, 32'd1);              expect_res("post_rst", 32'd99, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
